// File: rtl/csela_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csela_pipe_if : operand/result handshake bundle for csela_pipe       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface csela_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/csela_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csela_pipe : pipelined carry-select adder/subtractor, one BLK-bit    |
// |              block resolved per stage, valid/ready on both sides     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module csela_pipe #(
   parameter int WIDTH = 32,
   parameter int BLK   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   csela_pipe_if.slave    bus
);
   localparam int S = WIDTH / BLK;

   // Operands are kept right-aligned: the next block to resolve always sits in bits [BLK-1:0].
   logic [WIDTH-1:0] r_a   [S];
   logic [WIDTH-1:0] r_b   [S];
   logic [WIDTH-1:0] r_sum [S];
   logic [S-1:0]     r_c;
   logic [S-1:0]     r_v;
   logic             r_ovf;

   logic             w_adv;
   logic [WIDTH-1:0] w_a_in    [S];
   logic [WIDTH-1:0] w_b_in    [S];
   logic [WIDTH-1:0] w_sum_in  [S];
   logic [WIDTH-1:0] w_sum_out [S];
   logic [BLK:0]     w_blk     [S];
   logic [S-1:0]     w_c_in;
   logic [S-1:0]     w_c_out;
   logic [S-1:0]     w_v_in;
   logic             w_ovf;

   function automatic logic [BLK:0] blk_add(
      input logic [BLK-1:0] x,
      input logic [BLK-1:0] y,
      input logic           c
   );
      logic [BLK:0] s0;
      logic [BLK:0] s1;
      s0 = {1'b0, x} + {1'b0, y};
      s1 = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};
      return c ? s1 : s0;
   endfunction

   assign w_adv         = !r_v[S-1] || bus.out_ready;
   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_v[S-1];
   assign bus.sum       = r_sum[S-1];
   assign bus.cout      = r_c[S-1];
   assign bus.ovf       = r_ovf;

   always_comb begin
      w_a_in[0]   = bus.a;
      w_b_in[0]   = bus.sub ? ~bus.b : bus.b;
      w_c_in[0]   = bus.sub | bus.cin;
      w_v_in[0]   = bus.in_valid;
      w_sum_in[0] = '0;
      for (int k = 1; k < S; k++) begin
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_c_in[k]   = r_c[k-1];
         w_v_in[k]   = r_v[k-1];
         w_sum_in[k] = r_sum[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < S; k++) begin
         w_blk[k]                   = blk_add(w_a_in[k][BLK-1:0], w_b_in[k][BLK-1:0], w_c_in[k]);
         w_sum_out[k]               = w_sum_in[k];
         w_sum_out[k][k*BLK +: BLK] = w_blk[k][BLK-1:0];
         w_c_out[k]                 = w_blk[k][BLK];
      end
      // Carry into the MSB is recovered from the final block's top sum bit and operand bits.
      w_ovf = w_blk[S-1][BLK-1] ^ w_a_in[S-1][BLK-1] ^ w_b_in[S-1][BLK-1] ^ w_blk[S-1][BLK];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < S; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      end else if (w_adv) begin
         r_v <= w_v_in;
         for (int k = 0; k < S; k++) begin
            // The output stage only takes valid slots so the last result holds across bubbles.
            if ((k < S-1) || w_v_in[k]) begin
               r_a[k]   <= w_a_in[k] >> BLK;
               r_b[k]   <= w_b_in[k] >> BLK;
               r_sum[k] <= w_sum_out[k];
               r_c[k]   <= w_c_out[k];
            end
         end
         if (w_v_in[S-1]) begin
            r_ovf <= w_ovf;
         end
      end
   end
endmodule
`default_nettype wire
